// File: rtl/enc_pkg.sv
// Shared definitions for the key priority encoder slice.
//   CODE_W    : width of the binary key index
//   KEY_N     : number of key lines
//   IDLE_CODE : code presented when disabled or no key is pressed
//   evt_state_e : one-deep press-event queue state
//   prio_code : index of the highest pressed (low) key, IDLE_CODE if none
package enc_pkg;

  localparam int CODE_W = 3;
  localparam int KEY_N  = 8;
  localparam logic [CODE_W-1:0] IDLE_CODE = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } evt_state_e;

  // Scan upward so the highest pressed index overwrites lower ones.
  function automatic logic [CODE_W-1:0] prio_code(input logic [KEY_N-1:0] keys_n);
    logic [CODE_W-1:0] idx;
    idx = IDLE_CODE;
    for (int i = 0; i < KEY_N; i++) begin
      if (keys_n[i] == 1'b0) begin
        idx = CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a debounce filter. A new synchronised
// key vector must be seen unchanged for DEBOUNCE consecutive samples before
// it is committed to deb_n; any change in between restarts the count.
//   clk, rst : clock, asynchronous active-high reset
//   keys_n   : raw active-low key lines, asynchronous to clk
//   deb_n    : debounced, committed key vector (active-low)
module key_debouncer #(
  parameter int W        = 8,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] keys_n,
  output logic [W-1:0] deb_n
);

  logic [W-1:0]     s1_r;
  logic [W-1:0]     s2_r;
  logic [W-1:0]     deb_r;
  logic [W-1:0]     cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_r + CNT_W'(1);
  assign deb_n     = deb_r;

  // Synchroniser chain and debounce counter/candidate tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r   <= {W{1'b1}};
      s2_r   <= {W{1'b1}};
      deb_r  <= {W{1'b1}};
      cand_r <= {W{1'b1}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      s1_r <= keys_n;
      s2_r <= s1_r;
      if (s2_r == deb_r) begin
        // Back at the committed value: nothing pending.
        cand_r <= s2_r;
        cnt_r  <= {CNT_W{1'b0}};
      end else if (s2_r != cand_r) begin
        // New candidate (or a glitch): restart counting from this sample.
        cand_r <= s2_r;
        if (DEBOUNCE == 1) begin
          deb_r <= s2_r;
          cnt_r <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= CNT_W'(1);
        end
      end else if (cnt_inc_s == CNT_W'(DEBOUNCE)) begin
        deb_r <= cand_r;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_inc_s;
      end
    end
  end

endmodule

// File: rtl/key_priority_encoder.sv
// 74148-style 8-input active-low priority encoder with synchronised and
// debounced inputs, registered code/cascade flags and a one-deep press-event
// queue with valid/ready handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   ei_n      : enable in (active-low, synchronous)
//   keys_n    : raw active-low key lines
//   code      : index of highest pressed key (bit 7 highest), 111 when idle
//   gs_n      : low when enabled and a key is pressed
//   eo_n      : low when enabled and no key is pressed (cascade enable)
//   evt_valid, evt_code, evt_ready : press-event channel
//   overrun   : sticky, an event was lost while one was pending
module key_priority_encoder
  import enc_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ei_n,
  input  logic [KEY_N-1:0]  keys_n,
  output logic [CODE_W-1:0] code,
  output logic              gs_n,
  output logic              eo_n,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic              overrun
);

  logic [KEY_N-1:0]  deb_n_s;
  logic [CODE_W-1:0] next_code_s;
  logic              next_gs_n_s;
  logic              next_eo_n_s;
  logic              trig_s;

  logic [CODE_W-1:0] code_r;
  logic              gs_n_r;
  logic              eo_n_r;
  evt_state_e        state_r;
  logic              evt_valid_r;
  logic [CODE_W-1:0] evt_code_r;
  logic              overrun_r;

  key_debouncer #(
    .W        (KEY_N),
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .keys_n (keys_n),
    .deb_n  (deb_n_s)
  );

  // Next encoder outputs from the debounced keys and the enable.
  always_comb begin
    next_code_s = IDLE_CODE;
    next_gs_n_s = 1'b1;
    next_eo_n_s = 1'b1;
    if (ei_n) begin
      next_code_s = IDLE_CODE;
      next_gs_n_s = 1'b1;
      next_eo_n_s = 1'b1;
    end else if (deb_n_s == {KEY_N{1'b1}}) begin
      next_code_s = IDLE_CODE;
      next_gs_n_s = 1'b1;
      next_eo_n_s = 1'b0;
    end else begin
      next_code_s = prio_code(deb_n_s);
      next_gs_n_s = 1'b0;
      next_eo_n_s = 1'b1;
    end
  end

  // A press event is a new active group or a change of the winning code;
  // releases and hidden lower-priority presses do not qualify.
  assign trig_s = (next_gs_n_s == 1'b0) &&
                  ((gs_n_r == 1'b1) || (next_code_s != code_r));

  // Registered encoder outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r <= IDLE_CODE;
      gs_n_r <= 1'b1;
      eo_n_r <= 1'b1;
    end else begin
      code_r <= next_code_s;
      gs_n_r <= next_gs_n_s;
      eo_n_r <= next_eo_n_s;
    end
  end

  // Event queue FSM; a handshake and a new trigger on the same edge
  // replace the event in place so the consumer sees no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= EMPTY;
      evt_valid_r <= 1'b0;
      evt_code_r  <= {CODE_W{1'b0}};
      overrun_r   <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (trig_s) begin
            state_r     <= FULL;
            evt_valid_r <= 1'b1;
            evt_code_r  <= next_code_s;
          end else begin
            state_r     <= EMPTY;
            evt_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (evt_ready) begin
            overrun_r <= 1'b0;
            if (trig_s) begin
              state_r     <= FULL;
              evt_valid_r <= 1'b1;
              evt_code_r  <= next_code_s;
            end else begin
              state_r     <= EMPTY;
              evt_valid_r <= 1'b0;
            end
          end else if (trig_s) begin
            // Pending event is kept; the new one is lost.
            overrun_r <= 1'b1;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r     <= EMPTY;
          evt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign code      = code_r;
  assign gs_n      = gs_n_r;
  assign eo_n      = eo_n_r;
  assign evt_valid = evt_valid_r;
  assign evt_code  = evt_code_r;
  assign overrun   = overrun_r;

endmodule
